// File: rtl/arm_mmio.sv
// Data-side memory subsystem for the single-cycle arm core: word RAM plus an
// MMIO block with GPIO, a compare timer and a TX FIFO drained by valid/ready.
module arm_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic        irq,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    R_GPIO, R_TCOUNT, R_TCTRL, R_TCMP, R_TXDATA, R_TXSTAT, R_RSV6, R_RSV7
  } reg_e;

  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  logic [31:0] gpio_q, gpio_d, tcount_q, tcount_d, tcmp_q, tcmp_d;
  logic        en_q, en_d, match_q, match_d, irq_en_q, irq_en_d;
  logic        ovf_q, ovf_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] ram_idx;
  reg_e          sel;
  logic          mmio_wr, ram_wr, empty, full, pop, push, tx_wr;
  logic          unused_addr;

  assign ram_idx     = ALUResult[AW+1:2];
  assign sel         = reg_e'(ALUResult[4:2]);
  assign unused_addr = ^{ALUResult[30:5], ALUResult[1:0]};
  assign mmio_wr     = MemWrite & ALUResult[31];
  assign ram_wr      = MemWrite & ~ALUResult[31] & ~reset;
  assign tx_wr       = mmio_wr & (sel == R_TXDATA);

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign pop      = ~empty & tx_ready;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign push     = tx_wr & (~full | pop);

  assign gpio_out = gpio_q;
  assign irq      = match_q & irq_en_q;
  assign tx_valid = ~empty;
  assign tx_data  = fifo_q[rd_ptr_q];

  always_comb begin
    ReadData = '0;
    if (!ALUResult[31]) begin
      ReadData = ram_q[ram_idx];
    end else begin
      case (sel)
        R_GPIO:   ReadData = gpio_q;
        R_TCOUNT: ReadData = tcount_q;
        R_TCTRL:  ReadData = {29'b0, irq_en_q, match_q, en_q};
        R_TCMP:   ReadData = tcmp_q;
        R_TXSTAT: ReadData = {16'b0, 8'(cnt_q), 5'b0, ovf_q, full, empty};
        default:  ReadData = '0;
      endcase
    end
  end

  always_comb begin
    gpio_d   = gpio_q;
    tcount_d = en_q ? tcount_q + 32'd1 : tcount_q;
    tcmp_d   = tcmp_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    match_d  = match_q;
    ovf_d    = ovf_q;
    if (mmio_wr) begin
      case (sel)
        R_GPIO:   gpio_d = WriteData;
        R_TCOUNT: tcount_d = WriteData;
        R_TCTRL: begin
          en_d     = WriteData[0];
          irq_en_d = WriteData[2];
          if (WriteData[1]) match_d = 1'b0;
        end
        R_TCMP:   tcmp_d = WriteData;
        R_TXSTAT: if (WriteData[2]) ovf_d = 1'b0;
        default:  ;
      endcase
    end
    // Compare uses the pre-increment count; a set beats a same-cycle clear.
    if (en_q && tcount_q == tcmp_q) match_d = 1'b1;
    if (tx_wr && !push) ovf_d = 1'b1;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q   <= '0;
      tcount_q <= '0;
      tcmp_q   <= '0;
      en_q     <= 1'b0;
      match_q  <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      gpio_q   <= gpio_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      en_q     <= en_d;
      match_q  <= match_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage arrays are not reset; writes are blocked during reset.
  always_ff @(posedge clk) begin
    if (ram_wr) ram_q[ram_idx] <= WriteData;
    if (push && !reset) fifo_q[wr_ptr_q] <= WriteData;
  end
endmodule
